// File: rtl/run_det_pkg.sv
// rtl/run_det_pkg.sv - shared state encoding for the run-length detector channels
package run_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_MAXED   = 2'b10,
        ST_ILLEGAL = 2'b11
    } run_state_t;

endpackage

// File: rtl/run_det_chan.sv
// rtl/run_det_chan.sv - one detector channel: run FSM, counter, registered pulse and length
module run_det_chan
    import run_det_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int MIN_RUN = 1,
    parameter int MAX_RUN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             polarity,
    input  logic             x,
    output logic             y,
    output logic [CNT_W-1:0] run_len,
    output run_state_t       state
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);

    run_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             active;
    logic [CNT_W-1:0] cnt_inc;

    assign active  = (x == polarity);
    assign cnt_inc = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            y_q       <= 1'b0;
            run_len_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            y_q       <= y_d;
            run_len_q <= run_len_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        y_d       = 1'b0;
        run_len_d = run_len_q;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (active) begin
                        cnt_d   = 1'b1;
                        state_d = (MAX_RUN == 1) ? ST_MAXED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (active) begin
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == MAX_CNT) ? ST_MAXED : ST_RUN;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        if (cnt_q >= MIN_CNT) begin
                            y_d       = 1'b1;
                            run_len_d = cnt_q;
                        end
                    end
                end
                // Terminal state: report and swallow this sample, like the legacy detector.
                ST_MAXED: begin
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                    y_d       = 1'b1;
                    run_len_d = MAX_CNT;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign y       = y_q;
    assign run_len = run_len_q;
    assign state   = state_q;

endmodule

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - multi-channel run-length detector with parameter check and packed outputs
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 4,
    parameter int MIN_RUN  = 1,
    parameter int MAX_RUN  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      polarity,
    input  logic [CHANNELS-1:0]       x,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS*CNT_W-1:0] run_len,
    output logic [2*CHANNELS-1:0]     state
);

    if (!(MIN_RUN >= 1 && MIN_RUN <= MAX_RUN && MAX_RUN <= (2**CNT_W) - 1)) begin : g_bad_params
        $fatal(1, "run_length_detector: need 1 <= MIN_RUN <= MAX_RUN <= 2**CNT_W-1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        run_det_chan #(
            .CNT_W  (CNT_W),
            .MIN_RUN(MIN_RUN),
            .MAX_RUN(MAX_RUN)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en),
            .polarity(polarity),
            .x       (x[i]),
            .y       (y[i]),
            .run_len (run_len[i*CNT_W +: CNT_W]),
            .state   (state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_run_length_detector.sv
// tb/tb_run_length_detector.sv - self-checking bench for run_length_detector against a run-length model
module tb_run_length_detector;

    localparam int CH  = 4;
    localparam int MAX = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic        polarity = 1'b1;
    logic [3:0]  x = 4'hF;
    logic [3:0]  y1, y2;
    logic [15:0] rl1, rl2;
    logic [7:0]  st1, st2;

    int  pass_cnt = 0;
    int  total_cnt = 0;
    bit  chk_en = 1'b0;

    int  m_run [2][CH];
    bit  m_blk [2][CH];
    bit  m_y   [2][CH];
    int  m_len [2][CH];
    int  min_of [2] = '{1, 2};

    run_length_detector dut1 (
        .clk(clk), .reset(reset), .en(en), .polarity(polarity), .x(x),
        .y(y1), .run_len(rl1), .state(st1)
    );

    run_length_detector #(.MIN_RUN(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .polarity(polarity), .x(x),
        .y(y2), .run_len(rl2), .state(st2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Model: a run is a count of active samples; a saturated run reports on the next edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) begin
                if (reset) begin
                    m_run[k][c] = 0; m_blk[k][c] = 0; m_y[k][c] = 0; m_len[k][c] = 0;
                end else if (!en) begin
                    m_y[k][c] = 0;
                end else begin
                    m_y[k][c] = 0;
                    if (m_blk[k][c]) begin
                        m_y[k][c] = 1; m_len[k][c] = MAX; m_blk[k][c] = 0; m_run[k][c] = 0;
                    end else if (x[c] == polarity) begin
                        m_run[k][c] = m_run[k][c] + 1;
                        if (m_run[k][c] == MAX) m_blk[k][c] = 1;
                    end else if (m_run[k][c] > 0) begin
                        if (m_run[k][c] >= min_of[k]) begin
                            m_y[k][c] = 1; m_len[k][c] = m_run[k][c];
                        end
                        m_run[k][c] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < CH; c++) begin
                int exp_st;
                exp_st = m_blk[0][c] ? 2 : (m_run[0][c] > 0 ? 1 : 0);
                check($sformatf("y1[%0d]", c), int'(y1[c]), int'(m_y[0][c]));
                check($sformatf("run_len1[%0d]", c), int'(rl1[c*4 +: 4]), m_len[0][c]);
                check($sformatf("state1[%0d]", c), int'(st1[2*c +: 2]), exp_st);
                exp_st = m_blk[1][c] ? 2 : (m_run[1][c] > 0 ? 1 : 0);
                check($sformatf("y2[%0d]", c), int'(y2[c]), int'(m_y[1][c]));
                check($sformatf("run_len2[%0d]", c), int'(rl2[c*4 +: 4]), m_len[1][c]);
                check($sformatf("state2[%0d]", c), int'(st2[2*c +: 2]), exp_st);
            end
        end
    end

    // Apply one sample and return once the edge that took it has produced outputs.
    task automatic cyc(input logic r, input logic e, input logic p, input logic [3:0] xv);
        reset = r; en = e; polarity = p; x = xv;
        @(negedge clk);
    endtask

    logic [5:0] tbl [16] = '{
        6'b11_1111, 6'b11_1111, 6'b01_0000, 6'b11_1010, 6'b11_1111, 6'b11_0101,
        6'b10_0000, 6'b10_0011, 6'b00_1111, 6'b10_1100, 6'b11_1111, 6'b11_1111,
        6'b11_1111, 6'b11_1111, 6'b11_0000, 6'b11_0000
    };

    initial begin
        cyc(1, 1, 1, 4'hF);
        chk_en = 1'b1;
        cyc(1, 1, 1, 4'hF);
        check("reset_y", int'(y1), 0);
        check("reset_state", int'(st1), 0);
        check("reset_run_len", int'(rl1), 0);

        cyc(0, 1, 1, 4'hF);
        check("release_all_run", int'(st1), 8'h55);
        cyc(0, 1, 1, 4'h0);
        check("len1_all_pulse", int'(y1), 4'hF);
        check("len1_all_run_len", int'(rl1), 16'h1111);
        check("min2_len1_no_pulse", int'(y2), 0);
        cyc(0, 1, 1, 4'h0);

        cyc(0, 1, 1, 4'h1);
        check("end_st_a", int'(st1[1:0]), 1);
        cyc(0, 1, 1, 4'h1);
        check("end_st_b", int'(st1[1:0]), 1);
        cyc(0, 1, 1, 4'h0);
        check("end_st_c", int'(st1[1:0]), 0);
        check("end_y", int'(y1), 4'b0001);
        check("end_len", int'(rl1[3:0]), 2);
        check("min2_len2_pulse", int'(y2[0]), 1);
        check("min2_len2_len", int'(rl2[3:0]), 2);
        cyc(0, 1, 1, 4'h0);
        check("end_y_once", int'(y1[0]), 0);

        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 4'h2);
        check("sat_maxed", int'(st1[3:2]), 2);
        check("sat_no_early_y", int'(y1[1]), 0);
        cyc(0, 1, 1, 4'h2);
        check("sat_y", int'(y1), 4'b0010);
        check("sat_len", int'(rl1[7:4]), 3);
        check("sat_ignored_idle", int'(st1[3:2]), 0);
        cyc(0, 1, 1, 4'h2);
        check("sat_new_run", int'(st1[3:2]), 1);
        cyc(0, 1, 1, 4'h0);
        check("sat_new_run_len", int'(rl1[7:4]), 1);
        cyc(0, 1, 1, 4'h0);

        cyc(0, 1, 0, 4'b1011);
        cyc(0, 1, 0, 4'b1011);
        cyc(0, 1, 0, 4'b1111);
        check("pol_y", int'(y1), 4'b0100);
        check("pol_len", int'(rl1[11:8]), 2);
        cyc(0, 1, 1, 4'h0);

        cyc(0, 1, 1, 4'h8);
        cyc(0, 1, 1, 4'h8);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 4'h0);
            check("gap_no_y", int'(y1), 0);
            check("gap_hold_run", int'(st1[7:6]), 1);
        end
        cyc(0, 1, 1, 4'h0);
        check("gap_y", int'(y1), 4'b1000);
        check("gap_len", int'(rl1[15:12]), 2);
        cyc(0, 1, 1, 4'h0);

        cyc(0, 1, 1, 4'h1);
        cyc(0, 1, 1, 4'h1);
        cyc(1, 1, 1, 4'h0);
        check("rst_mid_state", int'(st1), 0);
        check("rst_mid_y", int'(y1), 0);
        check("rst_mid_len", int'(rl1), 0);
        cyc(0, 1, 1, 4'h0);
        check("rst_mid_no_pulse", int'(y1), 0);

        for (int i = 0; i < 16; i++) begin
            logic [5:0] v;
            v = tbl[i];
            cyc(0, v[5], v[4], v[3:0]);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
